// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS fetch stage.
// Holds reset PC, branch-type encodings, NOP and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'hbfc00000;
    localparam logic [3:0]  B_TYPE_BEQ = 4'b0001;
    localparam logic [3:0]  B_TYPE_BNE = 4'b0000;
    localparam logic [31:0] NOP        = 32'h0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BREQ  = 2'd1,
        ST_BHOLD = 2'd2
    } fe_state_e;

endpackage

// File: rtl/fetch_stage_next_pc_gen.sv
// Combinational next-PC resolution for the fetch stage.
// Branch targets are relative to the delay slot (current_pc + 4).
module next_pc_gen
    import cpu_pkg::*;
(
    input  logic [31:0] i_fetch_pc,
    input  logic [31:0] i_current_pc,
    input  logic        i_is_b,
    input  logic        i_is_j,
    input  logic        i_is_jr,
    input  logic [3:0]  i_b_type,
    input  logic [15:0] i_b_offset,
    input  logic [25:0] i_j_index,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_next_pc,
    output logic        o_taken
);

    logic [31:0] w_pc4;
    logic [31:0] w_boff;
    logic        w_eq;
    logic        w_cond;

    assign w_pc4  = i_current_pc + 32'd4;
    assign w_boff = {{14{i_b_offset[15]}}, i_b_offset, 2'b00};
    assign w_eq   = (i_src1 == i_src2);

    // Branch condition from the compare type
    always_comb begin
        w_cond = 1'b0;
        if (i_b_type == B_TYPE_BEQ) begin
            w_cond = w_eq;
        end else if (i_b_type == B_TYPE_BNE) begin
            w_cond = ~w_eq;
        end
    end

    assign o_taken = i_is_b & w_cond;

    // Target select: JR, then J/JAL, then taken branch, else sequential
    always_comb begin
        o_next_pc = i_fetch_pc + 32'd4;
        if (i_is_jr) begin
            o_next_pc = i_src1;
        end else if (i_is_j) begin
            o_next_pc = {w_pc4[31:28], i_j_index, 2'b00};
        end else if (o_taken) begin
            o_next_pc = w_pc4 + w_boff;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, SRAM drive, hold buffer, branch-hazard FSM.
// Optional misaligned-fetch flag fe_adel under FETCH_ADDR_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] fe_inst,
    output logic [31:0] current_pc,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] br_src1,
    input  logic [31:0] br_src2,
    input  logic        br_hazard,
    input  logic        stall,
`ifdef FETCH_ADDR_CHECK_EN
    output logic        fe_adel,
`endif
    output logic        stall_is_b
);

    import cpu_pkg::*;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_current_pc;
    logic [31:0] r_hold_inst;
    logic        r_valid;
    logic        r_hold_vld;
    fe_state_e   r_state;
    fe_state_e   w_state_nxt;
    logic        w_breq;
    logic        w_adv;
    logic [31:0] w_next_pc;
    logic        w_taken;

`ifdef FETCH_ADDR_CHECK_EN
    logic        r_adel;
    logic        w_fetch_mis;
    assign w_fetch_mis = (r_fetch_pc[1:0] != 2'b00);
`endif

    // Redirects only count when decode holds a real instruction
    next_pc_gen u_npc (
        .i_fetch_pc   (r_fetch_pc),
        .i_current_pc (r_current_pc),
        .i_is_b       (r_valid & de_is_b),
        .i_is_j       (r_valid & de_is_j),
        .i_is_jr      (r_valid & de_is_jr),
        .i_b_type     (de_b_type),
        .i_b_offset   (de_b_offset),
        .i_j_index    (de_j_index),
        .i_src1       (br_src1),
        .i_src2       (br_src2),
        .o_next_pc    (w_next_pc),
        .o_taken      (w_taken)
    );

    // Branch-hazard FSM next state and one-shot stall request
    always_comb begin
        w_state_nxt = r_state;
        w_breq      = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (~reset & r_valid & (de_is_b | de_is_jr)
                    & br_hazard & ~stall) begin
                    w_breq      = 1'b1;
                    w_state_nxt = ST_BREQ;
                end
            end
            ST_BREQ: begin
                if (stall) begin
                    w_state_nxt = ST_BHOLD;
                end
            end
            ST_BHOLD: begin
                if (~stall) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_adv = ~reset & ~stall & (r_state == ST_RUN) & ~w_breq;
    assign stall_is_b = w_breq;
    assign inst_sram_addr = r_fetch_pc;
    assign current_pc = r_current_pc;

`ifdef FETCH_ADDR_CHECK_EN
    assign inst_sram_en = w_adv & ~w_fetch_mis;
    assign fe_adel = r_adel;
`else
    assign inst_sram_en = w_adv;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC pipeline and hold buffer for the word in decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_current_pc <= 32'h0;
            r_valid      <= 1'b0;
            r_hold_vld   <= 1'b0;
            r_hold_inst  <= NOP;
        end else if (w_adv) begin
            r_current_pc <= r_fetch_pc;
            r_fetch_pc   <= w_next_pc;
            r_valid      <= 1'b1;
            r_hold_vld   <= 1'b0;
        end else if (r_valid & ~r_hold_vld) begin
            r_hold_inst  <= inst_sram_rdata;
            r_hold_vld   <= 1'b1;
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    // Misaligned-fetch flag follows the PC that entered decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adel <= 1'b0;
        end else if (w_adv) begin
            r_adel <= w_fetch_mis;
        end
    end
`endif

    // Word presented to decode: NOP, held copy, or live SRAM data
    always_comb begin
        fe_inst = NOP;
        if (r_valid) begin
            if (r_hold_vld) begin
                fe_inst = r_hold_inst;
            end else begin
                fe_inst = inst_sram_rdata;
            end
`ifdef FETCH_ADDR_CHECK_EN
            if (r_adel) begin
                fe_inst = NOP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: fetch order, delay slot, stall,
// branch hazard handshake and optional misaligned-fetch flag.
module tb_fetch_stage;

    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] fe_inst;
    logic [31:0] current_pc;
    logic        de_is_b;
    logic        de_is_j;
    logic        de_is_jr;
    logic [3:0]  de_b_type;
    logic [15:0] de_b_offset;
    logic [25:0] de_j_index;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        hz;
    logic        stall;
    logic        stall_is_b;
`ifdef FETCH_ADDR_CHECK_EN
    logic        fe_adel;
`endif

    logic        b_en;
    logic        j_en;
    logic        jr_en;
    logic [3:0]  b_type;
    logic        force_sram;

    int          tests;
    int          fails;
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (en),
        .inst_sram_addr  (addr),
        .inst_sram_rdata (rdata),
        .fe_inst         (fe_inst),
        .current_pc      (current_pc),
        .de_is_b         (de_is_b),
        .de_is_j         (de_is_j),
        .de_is_jr        (de_is_jr),
        .de_b_type       (de_b_type),
        .de_b_offset     (de_b_offset),
        .de_j_index      (de_j_index),
        .br_src1         (src1),
        .br_src2         (src2),
        .br_hazard       (hz),
        .stall           (stall),
`ifdef FETCH_ADDR_CHECK_EN
        .fe_adel         (fe_adel),
`endif
        .stall_is_b      (stall_is_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: word = ~address, one cycle latency
    always @(posedge clk) begin
        if (force_sram) begin
            rdata <= 32'hdeadbeef;
        end else if (en) begin
            rdata <= ~addr;
        end
    end

    // Decode model: control transfers keyed on the PC in decode
    always_comb begin
        de_is_b     = b_en && (current_pc == 32'hbfc00010);
        de_b_type   = b_type;
        de_b_offset = 16'h0003;
        de_is_j     = j_en && (current_pc == 32'hbfc00020);
        de_j_index  = 26'h0000100;
        de_is_jr    = jr_en && (current_pc == 32'hbfc00010);
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop expected address on each issued fetch, then
    // check that word reaches decode on the following cycle
    initial begin : mon
        logic        pv;
        logic [31:0] pe;
        logic [31:0] e;
        pv = 1'b0;
        pe = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (pv) begin
                chk("dec_pc", current_pc, pe);
                chk("dec_inst", fe_inst, ~pe);
            end
            pv = 1'b0;
            if (en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fetch_addr", addr, e);
                pv = 1'b1;
                pe = e;
            end
        end
    end

    task automatic hold_reset();
        reset = 1'b1;
        stall = 1'b0;
        hz = 1'b0;
        force_sram = 1'b0;
        b_en = 1'b0;
        j_en = 1'b0;
        jr_en = 1'b0;
        b_type = B_TYPE_BEQ;
        src1 = 32'h0;
        src2 = 32'h0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_sib", 32'(stall_is_b), 32'd0);
        chk("rst_inst", fe_inst, 32'h0);
        chk("rst_cpc", current_pc, 32'h0);
        chk("rst_addr", addr, 32'hbfc00000);
`ifdef FETCH_ADDR_CHECK_EN
        chk("rst_adel", 32'(fe_adel), 32'd0);
`endif
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        chk("rel_en", 32'(en), 32'd1);
        chk("rel_inst", fe_inst, 32'h0);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic wait_cpc(input logic [31:0] target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (current_pc == target) hit = 1'b1;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL wait_cpc: timeout, got %h, expected %h",
                     current_pc, target);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        stall = 1'b0;
        hz = 1'b0;
        force_sram = 1'b0;
        b_en = 1'b0;
        j_en = 1'b0;
        jr_en = 1'b0;
        b_type = B_TYPE_BEQ;
        src1 = 32'h0;
        src2 = 32'h0;

        // BEQ taken at bfc00010, then J at bfc00020
        hold_reset();
        b_en = 1'b1;
        j_en = 1'b1;
        src1 = 32'd5;
        src2 = 32'd5;
        push_seq(32'hbfc00000, 6);
        exp_q.push_back(32'hbfc00020);
        exp_q.push_back(32'hbfc00024);
        exp_q.push_back(32'hb0000400);
        exp_q.push_back(32'hb0000404);
        release_reset();
        drain();

        // BNE with equal operands falls through
        hold_reset();
        b_en = 1'b1;
        b_type = B_TYPE_BNE;
        src1 = 32'd5;
        src2 = 32'd5;
        push_seq(32'hbfc00000, 8);
        release_reset();
        drain();

        // Two-cycle stall while SRAM output is corrupted
        hold_reset();
        push_seq(32'hbfc00000, 6);
        release_reset();
        wait_cpc(32'hbfc00008);
        stall = 1'b1;
        force_sram = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stl_en", 32'(en), 32'd0);
            chk("stl_inst", fe_inst, ~32'hbfc00008);
            chk("stl_cpc", current_pc, 32'hbfc00008);
            chk("stl_addr", addr, 32'hbfc0000c);
        end
        stall = 1'b0;
        force_sram = 1'b0;
        drain();

        // JR with operand hazard: request, stall, resolve
        hold_reset();
        jr_en = 1'b1;
        hz = 1'b1;
        src1 = 32'h12345678;
        push_seq(32'hbfc00000, 6);
        exp_q.push_back(32'hbfc00100);
        exp_q.push_back(32'hbfc00104);
        release_reset();
        wait_cpc(32'hbfc00010);
        chk("jr_sib_req", 32'(stall_is_b), 32'd1);
        chk("jr_en_req", 32'(en), 32'd0);
        @(negedge clk);
        chk("jr_sib_wait", 32'(stall_is_b), 32'd0);
        chk("jr_en_wait", 32'(en), 32'd0);
        stall = 1'b1;
        @(negedge clk);
        chk("jr_sib_hold", 32'(stall_is_b), 32'd0);
        chk("jr_en_hold", 32'(en), 32'd0);
        chk("jr_inst_hold", fe_inst, ~32'hbfc00010);
        stall = 1'b0;
        hz = 1'b0;
        src1 = 32'hbfc00100;
        drain();

`ifdef FETCH_ADDR_CHECK_EN
        // JR to a misaligned target
        hold_reset();
        jr_en = 1'b1;
        src1 = 32'hbfc00102;
        push_seq(32'hbfc00000, 6);
        release_reset();
        wait_cpc(32'hbfc00014);
        chk("adel_en", 32'(en), 32'd0);
        chk("adel_addr", addr, 32'hbfc00102);
        @(negedge clk);
        chk("adel_cpc", current_pc, 32'hbfc00102);
        chk("adel_inst", fe_inst, 32'h0);
        chk("adel_flag", 32'(fe_adel), 32'd1);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
